// File: rtl/add_arbiter_rr_pkg.sv
// add_arbiter_rr_pkg: shared widths and pipeline stage types for add_arbiter_rr.
// No ports. The stage structs are sized from the defaults below.
// Resize the whole design by editing this package.
package add_arbiter_rr_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;
    localparam int HW        = W_DEF / 2;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = idw(N_REQ_DEF);

    // S1: low-half sum with its carry, plus the untouched high operand halves.
    typedef struct packed {
        logic               valid;
        logic [IDW_DEF-1:0] tag;
        logic [HW-1:0]      lo;
        logic               c;
        logic [HW-1:0]      a_hi;
        logic [HW-1:0]      b_hi;
    } s1_t;

    typedef struct packed {
        logic               valid;
        logic [IDW_DEF-1:0] tag;
        logic [W_DEF-1:0]   sum;
        logic               cout;
    } s2_t;
endpackage

// File: rtl/add_pipe2_w.sv
// add_pipe2_w: 2-stage split-carry adder with an advance enable and a valid/tag sideband.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   adv_i           advance; when low, both stages hold
//   valid_i, tag_i  item valid and requester tag entering S1
//   a_i, b_i        operands
//   valid_o, tag_o  S2 valid and tag
//   sum_o, cout_o   registered sum and carry out
//   busy_o          any stage holds a valid item
module add_pipe2_w
    import add_arbiter_rr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_i,
    input  logic               valid_i,
    input  logic [IDW_DEF-1:0] tag_i,
    input  logic [W_DEF-1:0]   a_i,
    input  logic [W_DEF-1:0]   b_i,
    output logic               valid_o,
    output logic [IDW_DEF-1:0] tag_o,
    output logic [W_DEF-1:0]   sum_o,
    output logic               cout_o,
    output logic               busy_o
);
    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    logic [HW:0] lo_sum, hi_sum;

    always_comb begin
        lo_sum = {1'b0, a_i[HW-1:0]} + {1'b0, b_i[HW-1:0]};
        s1_d   = '{valid: valid_i, tag: tag_i, lo: lo_sum[HW-1:0], c: lo_sum[HW],
                   a_hi: a_i[W_DEF-1:HW], b_hi: b_i[W_DEF-1:HW]};
        hi_sum = {1'b0, s1_q.a_hi} + {1'b0, s1_q.b_hi} + {{HW{1'b0}}, s1_q.c};
        s2_d   = '{valid: s1_q.valid, tag: s1_q.tag,
                   sum: {hi_sum[HW-1:0], s1_q.lo}, cout: hi_sum[HW]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (adv_i) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign valid_o = s2_q.valid;
    assign tag_o   = s2_q.tag;
    assign sum_o   = s2_q.sum;
    assign cout_o  = s2_q.cout;
    assign busy_o  = s1_q.valid | s2_q.valid;
endmodule

// File: rtl/add_arbiter_rr.sv
// add_arbiter_rr: arbitrates N_REQ requesters onto one shared 2-stage pipelined adder.
// Macro ADD_ARB_RR_EN: when defined, round-robin grant from a rotating pointer;
// when undefined, fixed priority with the lowest index winning and no pointer.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (ready is one-hot or zero)
//   req_a/req_b                 packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready         response handshake; rsp_ready also advances the pipeline
//   rsp_id, rsp_sum, rsp_cout   tagged result
//   busy                        any pipeline stage holds a valid item
module add_arbiter_rr
    import add_arbiter_rr_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int IDW   = idw(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout,
    output logic               busy
);
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id, idx;
    logic             found, adv, hs;

`ifdef ADD_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;
`endif

    // Scan from the pointer (or from 0) and take the first asserted request.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ADD_ARB_RR_EN
            idx = IDW'((int'(ptr_q) + k) % N_REQ);
`else
            idx = IDW'(k);
`endif
            if (!found && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

    // A stalled pipeline cannot take a new item, so ready is gated by the advance.
    assign adv       = rsp_ready;
    assign req_ready = gnt & {N_REQ{adv & rst_n}};
    assign hs        = found & adv & rst_n;

`ifdef ADD_ARB_RR_EN
    assign ptr_d = hs ? ((gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1) : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    add_pipe2_w u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .valid_i (hs),
        .tag_i   (gnt_id),
        .a_i     (req_a[gnt_id*W +: W]),
        .b_i     (req_b[gnt_id*W +: W]),
        .valid_o (rsp_valid),
        .tag_o   (rsp_id),
        .sum_o   (rsp_sum),
        .cout_o  (rsp_cout),
        .busy_o  (busy)
    );
endmodule

// File: tb/tb_add_arbiter_rr.sv
// tb_add_arbiter_rr: directed self-checking bench for add_arbiter_rr.
module tb_add_arbiter_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout, busy;
    int          checks = 0;
    int          failures = 0;

`ifdef ADD_ARB_RR_EN
    int g_seq[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] g13[4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
    int g_seq[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] g13[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
    int sum_tab[4] = '{19, 36, 53, 70};
    int q[$];
    int s;

    always #5 clk = ~clk;

    add_arbiter_rr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_one(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ec);
        req_a = '0;
        req_b = '0;
        req_a[r*8 +: 8] = a;
        req_b[r*8 +: 8] = b;
        req_valid = 4'(1 << r);
        #1 chk("one_ready", 32'(req_ready), 32'(1 << r));
        step();
        req_valid = '0;
        #1 chk("one_busy", 32'(busy), 1);
        chk("one_early", 32'(rsp_valid), 0);
        step();
        #1 chk("one_valid", 32'(rsp_valid), 1);
        chk("one_id", 32'(rsp_id), 32'(r));
        chk("one_sum", 32'(rsp_sum), 32'(es));
        chk("one_cout", 32'(rsp_cout), 32'(ec));
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_cout", 32'(rsp_cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        run_one(0, 8'd15, 8'd15, 8'd30, 1'b0);
        run_one(2, 8'd255, 8'd255, 8'd254, 1'b1);
        run_one(1, 8'h0F, 8'h01, 8'h10, 1'b0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_a = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b = {8'd6, 8'd5, 8'd4, 8'd3};
        req_valid = 4'hF;
        s = 0;
        for (int c = 0; c < 14; c++) begin
            logic stall;
            stall = (c >= 6 && c <= 8);
            rsp_ready = !stall;
            #1 chk("str_ready", 32'(req_ready), stall ? 0 : 32'(1 << g_seq[s]));
            if (c >= 2) begin
                chk("str_valid", 32'(rsp_valid), 1);
                chk("str_id", 32'(rsp_id), 32'(q[0]));
                chk("str_sum", 32'(rsp_sum), 32'(sum_tab[q[0]]));
            end
            if (!stall) begin
                q.push_back(g_seq[s]);
                s++;
                if (c >= 2) void'(q.pop_front());
            end
            step();
        end

        #1 chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1 chk("mid_valid", 32'(rsp_valid), 0);
        chk("mid_busy0", 32'(busy), 0);
        chk("mid_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_first", 32'(req_ready), 32'b0001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("r13_ready", 32'(req_ready), 32'(g13[i]));
            step();
        end
        req_valid = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
